// File: rtl/fifo_to_axis.sv
// Drains a show-ahead FIFO into a registered valid/ready stream framed into fixed-length packets.
// Optional FIFO2AXIS_PAD_EN closes stalled packets with zero padding beats flagged on tuser_o.
module fifo_to_axis #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_PKT_LEN = 256,
  parameter int PAD_TIMEOUT = 16,
  parameter int LEN_WIDTH   = $clog2(MAX_PKT_LEN) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic                  fifo_rd_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  fifo_empty_i,
  input  logic [LEN_WIDTH-1:0]  pkt_len_i,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic                  tlast_o,
  output logic                  tuser_o,
  output logic [15:0]           pkt_cnt_o,
  output logic                  busy_o
);

`ifdef FIFO2AXIS_PAD_EN
  typedef enum logic [1:0] {IDLE, BODY, PAD} state_t;
  localparam int IDLE_W = $clog2(PAD_TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
`else
  typedef enum logic {IDLE, BODY} state_t;
`endif

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] tdata_reg, tdata_next;
  logic                  tvalid_reg, tvalid_next;
  logic                  tlast_reg, tlast_next;
  logic                  tuser_reg, tuser_next;
  logic [15:0]           pkt_cnt_reg;
  logic [LEN_WIDTH-1:0]  beat_cnt_reg, beat_cnt_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic [LEN_WIDTH-1:0]  len_in;
  logic                  load, pop, last_beat;

  assign load = !tvalid_reg || tready_i;
`ifdef FIFO2AXIS_PAD_EN
  assign pop = load && !fifo_empty_i && (state_reg != PAD);
`else
  assign pop = load && !fifo_empty_i;
`endif
  assign last_beat = (beat_cnt_reg == len_reg - LEN_WIDTH'(1));

  // Zero-length requests become single-beat packets; oversize requests clamp.
  always_comb begin
    len_in = pkt_len_i;
    if (pkt_len_i == '0)
      len_in = LEN_WIDTH'(1);
    else if (pkt_len_i > LEN_WIDTH'(MAX_PKT_LEN))
      len_in = LEN_WIDTH'(MAX_PKT_LEN);
  end

  always_comb begin
    state_next    = state_reg;
    tdata_next    = tdata_reg;
    tvalid_next   = tvalid_reg;
    tlast_next    = tlast_reg;
    tuser_next    = tuser_reg;
    beat_cnt_next = beat_cnt_reg;
    len_next      = len_reg;
`ifdef FIFO2AXIS_PAD_EN
    idle_cnt_next = idle_cnt_reg;
`endif
    if (pop) begin
      tdata_next  = fifo_rd_data_i;
      tvalid_next = 1'b1;
      tuser_next  = 1'b0;
      tlast_next  = 1'b0;
      if (state_reg == IDLE) begin
        len_next = len_in;
        if (len_in == LEN_WIDTH'(1)) begin
          tlast_next = 1'b1;
        end else begin
          state_next    = BODY;
          beat_cnt_next = LEN_WIDTH'(1);
        end
      end else if (last_beat) begin
        tlast_next    = 1'b1;
        state_next    = IDLE;
        beat_cnt_next = '0;
      end else begin
        beat_cnt_next = beat_cnt_reg + LEN_WIDTH'(1);
      end
`ifdef FIFO2AXIS_PAD_EN
    end else if (load && state_reg == PAD) begin
      tdata_next  = '0;
      tvalid_next = 1'b1;
      tuser_next  = 1'b1;
      tlast_next  = 1'b0;
      if (last_beat) begin
        tlast_next    = 1'b1;
        state_next    = IDLE;
        beat_cnt_next = '0;
      end else begin
        beat_cnt_next = beat_cnt_reg + LEN_WIDTH'(1);
      end
`endif
    end else if (load) begin
      tvalid_next = 1'b0;
      tlast_next  = 1'b0;
      tuser_next  = 1'b0;
    end
`ifdef FIFO2AXIS_PAD_EN
    // Only starvation counts as idle; a stalled sink is not a reason to pad.
    if (state_reg != BODY || pop) begin
      idle_cnt_next = '0;
    end else if (fifo_empty_i && load) begin
      if (idle_cnt_reg == IDLE_W'(PAD_TIMEOUT - 1)) begin
        idle_cnt_next = IDLE_W'(PAD_TIMEOUT);
        state_next    = PAD;
      end else begin
        idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      tdata_reg    <= '0;
      tvalid_reg   <= 1'b0;
      tlast_reg    <= 1'b0;
      tuser_reg    <= 1'b0;
      pkt_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
      len_reg      <= LEN_WIDTH'(1);
`ifdef FIFO2AXIS_PAD_EN
      idle_cnt_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      tdata_reg    <= tdata_next;
      tvalid_reg   <= tvalid_next;
      tlast_reg    <= tlast_next;
      tuser_reg    <= tuser_next;
      beat_cnt_reg <= beat_cnt_next;
      len_reg      <= len_next;
`ifdef FIFO2AXIS_PAD_EN
      idle_cnt_reg <= idle_cnt_next;
`endif
      if (tvalid_reg && tready_i && tlast_reg)
        pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
    end
  end

  assign fifo_rd_o = pop;
  assign tdata_o   = tdata_reg;
  assign tvalid_o  = tvalid_reg;
  assign tlast_o   = tlast_reg;
  assign tuser_o   = tuser_reg;
  assign pkt_cnt_o = pkt_cnt_reg;
  assign busy_o    = (state_reg != IDLE);

endmodule

// File: tb/tb_fifo_to_axis.sv
// Directed bench for fifo_to_axis: a simple array FIFO model feeds the DUT, accepted beats are logged.
module tb_fifo_to_axis;
  localparam int DW = 8;
  localparam int MAXL = 256;
  localparam int LW = $clog2(MAXL) + 1;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          fifo_rd_o;
  logic [DW-1:0] fifo_rd_data_i;
  logic          fifo_empty_i;
  logic [LW-1:0] pkt_len_i = '0;
  logic [DW-1:0] tdata_o;
  logic          tvalid_o;
  logic          tready_i = 1'b1;
  logic          tlast_o;
  logic          tuser_o;
  logic [15:0]   pkt_cnt_o;
  logic          busy_o;

  fifo_to_axis #(.DATA_WIDTH(DW), .MAX_PKT_LEN(MAXL), .PAD_TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .fifo_rd_o(fifo_rd_o), .fifo_rd_data_i(fifo_rd_data_i),
    .fifo_empty_i(fifo_empty_i), .pkt_len_i(pkt_len_i), .tdata_o(tdata_o), .tvalid_o(tvalid_o),
    .tready_i(tready_i), .tlast_o(tlast_o), .tuser_o(tuser_o), .pkt_cnt_o(pkt_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: show-ahead head word, popped on fifo_rd_o.
  logic [DW-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty_i   = (rd_ptr == wr_ptr);
  assign fifo_rd_data_i = mem[rd_ptr[9:0]];
  always @(posedge clk_i) if (fifo_rd_o) rd_ptr <= rd_ptr + 1;

  // Beat log and protocol watchdogs.
  logic [DW-1:0] cap_data [0:1023];
  logic          cap_last [0:1023];
  logic          cap_user [0:1023];
  int            cap_cyc  [0:1023];
  int            cap_n = 0;
  int            cyc = 0;
  logic          bad_pop = 1'b0, stall_pop = 1'b0, hold_viol = 1'b0;
  logic          prev_stall = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (tvalid_o && tready_i) begin
      cap_data[cap_n[9:0]] <= tdata_o;
      cap_last[cap_n[9:0]] <= tlast_o;
      cap_user[cap_n[9:0]] <= tuser_o;
      cap_cyc[cap_n[9:0]]  <= cyc;
      cap_n <= cap_n + 1;
    end
    if (fifo_rd_o && fifo_empty_i) bad_pop <= 1'b1;
    if (fifo_rd_o && tvalid_o && !tready_i) stall_pop <= 1'b1;
    if (rst_n_i && prev_stall && (!tvalid_o || tdata_o !== prev_data || tlast_o !== prev_last))
      hold_viol <= 1'b1;
    prev_stall <= rst_n_i && tvalid_o && !tready_i;
    prev_data  <= tdata_o;
    prev_last  <= tlast_o;
  end

  int checks = 0;
  int errors = 0;

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr[9:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_beats(input int base, input int n, input int budget, input logic toggle);
    int k;
    k = 0;
    while ((cap_n - base) < n && k < budget) begin
      @(negedge clk_i);
      if (toggle) tready_i = ~tready_i;
      k++;
    end
    checks++;
    if ((cap_n - base) < n) begin
      errors++;
      $display("FAIL beat_timeout got %0d beats required %0d", cap_n - base, n);
    end
    tready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      checks++;
      if ({fifo_rd_o, tvalid_o, busy_o} !== 3'b000 || pkt_cnt_o !== 16'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d rd/valid/busy=%b pkt_cnt=%0d required 000/0", i,
                 {fifo_rd_o, tvalid_o, busy_o}, pkt_cnt_o);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_stream4();
    int base;
    base = cap_n;
    pkt_len_i = LW'(4);
    for (int i = 0; i < 8; i++) push(8'h10 + DW'(i));
    @(negedge clk_i);
    checks++;
    if (tvalid_o !== 1'b1 || tdata_o !== 8'h10) begin
      errors++;
      $display("FAIL first_latency valid=%b data=%h required 1/10", tvalid_o, tdata_o);
    end
    wait_beats(base, 8, 40, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_data[base+i] !== 8'h10 + DW'(i) || cap_last[base+i] !== (i % 4 == 3) || cap_user[base+i] !== 1'b0) begin
        errors++;
        $display("FAIL len4_beat%0d data=%h last=%b user=%b required %h/%b/0", i, cap_data[base+i],
                 cap_last[base+i], cap_user[base+i], 8'h10 + DW'(i), (i % 4 == 3));
      end
    end
    checks++;
    if (cap_cyc[base+7] - cap_cyc[base] != 7) begin
      errors++;
      $display("FAIL throughput span=%0d cycles required 7", cap_cyc[base+7] - cap_cyc[base]);
    end
    checks++;
    if (pkt_cnt_o !== 16'd2 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL len4_count pkt_cnt=%0d busy=%b required 2/0", pkt_cnt_o, busy_o);
    end
    $display("test_stream4 beats=%0d pkt_cnt=%0d", cap_n - base, pkt_cnt_o);
  endtask

  task automatic test_backpressure();
    int base;
    base = cap_n;
    pkt_len_i = LW'(3);
    for (int i = 0; i < 6; i++) push(8'h20 + DW'(i));
    wait_beats(base, 6, 60, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cap_data[base+i] !== 8'h20 + DW'(i) || cap_last[base+i] !== (i % 3 == 2)) begin
        errors++;
        $display("FAIL bp_beat%0d data=%h last=%b required %h/%b", i, cap_data[base+i], cap_last[base+i],
                 8'h20 + DW'(i), (i % 3 == 2));
      end
    end
    checks++;
    if (hold_viol !== 1'b0 || stall_pop !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold hold_viol=%b stall_pop=%b required 0/0", hold_viol, stall_pop);
    end
    checks++;
    if (pkt_cnt_o !== 16'd4 || cap_n - base != 6) begin
      errors++;
      $display("FAIL bp_count pkt_cnt=%0d beats=%0d required 4/6", pkt_cnt_o, cap_n - base);
    end
    $display("test_backpressure beats=%0d pkt_cnt=%0d", cap_n - base, pkt_cnt_o);
  endtask

  task automatic test_len_bounds();
    int base;
    base = cap_n;
    pkt_len_i = '0;
    for (int i = 0; i < 3; i++) push(8'h30 + DW'(i));
    wait_beats(base, 3, 30, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap_data[base+i] !== 8'h30 + DW'(i) || cap_last[base+i] !== 1'b1) begin
        errors++;
        $display("FAIL len0_beat%0d data=%h last=%b required %h/1", i, cap_data[base+i], cap_last[base+i],
                 8'h30 + DW'(i));
      end
    end
    base = cap_n;
    pkt_len_i = LW'(MAXL + 5);
    for (int i = 0; i < 512; i++) push(DW'(i));
    wait_beats(base, 512, 700, 1'b0);
    for (int i = 0; i < 512; i++) begin
      checks++;
      if (cap_data[base+i] !== DW'(i) || cap_last[base+i] !== (i % MAXL == MAXL - 1)) begin
        errors++;
        $display("FAIL lenmax_beat%0d data=%h last=%b required %h/%b", i, cap_data[base+i], cap_last[base+i],
                 DW'(i), (i % MAXL == MAXL - 1));
        break;
      end
    end
    checks++;
    if (pkt_cnt_o !== 16'd9 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL len_bounds_count pkt_cnt=%0d busy=%b required 9/0", pkt_cnt_o, busy_o);
    end
    $display("test_len_bounds pkt_cnt=%0d", pkt_cnt_o);
  endtask

  task automatic test_midpacket_reset();
    int base;
    base = cap_n;
    pkt_len_i = LW'(4);
    push(8'h40);
    push(8'h41);
    wait_beats(base, 2, 20, 1'b0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midpkt_busy busy=%b required 1", busy_o);
    end
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({tvalid_o, tlast_o, tuser_o, busy_o} !== 4'b0000 || tdata_o !== 8'h00 || pkt_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL async_reset valid/last/user/busy=%b data=%h pkt_cnt=%0d required 0000/00/0",
               {tvalid_o, tlast_o, tuser_o, busy_o}, tdata_o, pkt_cnt_o);
    end
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    base = cap_n;
    for (int i = 0; i < 4; i++) push(8'h50 + DW'(i));
    wait_beats(base, 4, 30, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_data[base+i] !== 8'h50 + DW'(i) || cap_last[base+i] !== (i == 3)) begin
        errors++;
        $display("FAIL post_reset_beat%0d data=%h last=%b required %h/%b", i, cap_data[base+i],
                 cap_last[base+i], 8'h50 + DW'(i), (i == 3));
      end
    end
    checks++;
    if (pkt_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_count pkt_cnt=%0d required 1", pkt_cnt_o);
    end
    $display("test_midpacket_reset pkt_cnt=%0d", pkt_cnt_o);
  endtask

`ifdef FIFO2AXIS_PAD_EN
  task automatic test_pad();
    int base;
    logic [DW-1:0] exp_d [0:4];
    exp_d[0] = 8'h60; exp_d[1] = 8'h61; exp_d[2] = 8'h00; exp_d[3] = 8'h00; exp_d[4] = 8'h00;
    base = cap_n;
    pkt_len_i = LW'(5);
    push(8'h60);
    push(8'h61);
    wait_beats(base, 5, 80, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap_data[base+i] !== exp_d[i] || cap_user[base+i] !== (i >= 2) || cap_last[base+i] !== (i == 4)) begin
        errors++;
        $display("FAIL pad_beat%0d data=%h user=%b last=%b required %h/%b/%b", i, cap_data[base+i],
                 cap_user[base+i], cap_last[base+i], exp_d[i], (i >= 2), (i == 4));
      end
    end
    checks++;
    if (cap_cyc[base+2] - cap_cyc[base+1] < 16 || pkt_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL pad_timing gap=%0d pkt_cnt=%0d required >=16/2", cap_cyc[base+2] - cap_cyc[base+1], pkt_cnt_o);
    end
    $display("test_pad pkt_cnt=%0d", pkt_cnt_o);
  endtask
`endif

  initial begin
    test_reset();
    test_stream4();
    test_backpressure();
    test_len_bounds();
    test_midpacket_reset();
`ifdef FIFO2AXIS_PAD_EN
    test_pad();
`endif
    checks++;
    if (bad_pop !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop seen=%b required 0", bad_pop);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
